// File: rtl/booth_mult16_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier and its adder16 datapath.
package booth_mult16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ADD_S = 3'b000;
  localparam logic [2:0] SUB_S = 3'b010;

  localparam int         N_STEPS   = 16;
  localparam logic [3:0] LAST_STEP = 4'(N_STEPS - 1);

endpackage

// File: rtl/booth_mult16_adder16.sv
// adder16: 16-bit combinational add/sub/logic unit with overflow flag and gated carry out.
// CODE: 000 signed add, 001 unsigned add, 010 signed sub, 011 unsigned sub, 1xx logic ops.
module adder16
  import booth_mult16_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [2:0]  CODE,
  input  logic        cin,
  input  logic        coe,
  output logic [15:0] C,
  output logic        vout,
  output logic        cout
);

  logic        w_sub;
  logic [15:0] w_bx;
  logic [16:0] w_sum;
  logic        w_carry;

  always_comb begin
    w_sub   = CODE[1];
    w_bx    = w_sub ? ~B : B;
    w_sum   = {1'b0, A} + {1'b0, w_bx} + {16'b0, w_sub ^ cin};
    C       = w_sum[15:0];
    vout    = 1'b0;
    w_carry = 1'b0;
    if (!CODE[2]) begin
      w_carry = w_sum[16];
      // Unsigned codes flag carry (add) or borrow (sub); signed codes flag two's-complement overflow.
      if (CODE[0]) begin
        vout = w_sum[16] ^ w_sub;
      end else begin
        vout = (A[15] == w_bx[15]) && (w_sum[15] != A[15]);
      end
    end else begin
      case (CODE[1:0])
        2'b00:   C = A & B;
        2'b01:   C = A | B;
        2'b10:   C = A ^ B;
        default: C = A;
      endcase
    end
    cout = coe ? 1'b0 : w_carry;
  end

endmodule

// File: rtl/booth_mult16.sv
// booth_mult16: sequential 16x16 signed radix-2 Booth multiplier, one add/sub-and-shift per clock,
// using a single adder16 instance; start/busy/done handshake with a held 32-bit product.
module booth_mult16
  import booth_mult16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_q;
  logic [15:0] r_m;
  logic        r_qm1;
  logic [3:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_product;

  logic        w_op;
  logic [2:0]  w_code;
  logic [15:0] w_c;
  logic        w_vout;
  logic        w_cout_unused;
  logic [15:0] w_s;
  logic        w_sign;
  logic [15:0] w_a_next;
  logic [15:0] w_q_next;

  adder16 u_adder (
    .A    (r_a),
    .B    (r_m),
    .CODE (w_code),
    .cin  (1'b0),
    .coe  (1'b1),
    .C    (w_c),
    .vout (w_vout),
    .cout (w_cout_unused)
  );

  // The injected sign uses C[15]^vout so the shift keeps the true 17-bit sign when A+-M overflows.
  always_comb begin
    w_op     = r_q[0] ^ r_qm1;
    w_code   = (r_q[0] && !r_qm1) ? SUB_S : ADD_S;
    w_s      = w_op ? w_c : r_a;
    w_sign   = w_op ? (w_c[15] ^ w_vout) : r_a[15];
    w_a_next = {w_sign, w_s[15:1]};
    w_q_next = {w_s[0], r_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_qm1     <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_qm1   <= r_q[0];
          r_count <= r_count + 4'd1;
          if (r_count == LAST_STEP) begin
            r_product <= {w_a_next, w_q_next};
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_mult16.sv
// Self-checking bench for booth_mult16: operation-level reference model plus directed and random operations.
module tb_booth_mult16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  // Reference model: an accepted start completes 16 edges later with the arithmetic product.
  int          mRemain = 0;
  logic        mDone = 1'b0;
  logic [31:0] mProd = '0;
  logic [31:0] mPending = '0;

  booth_mult16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refMul(input logic [15:0] m, input logic [15:0] q);
    logic signed [31:0] p;
    p = $signed(m) * $signed(q);
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRemain = 0;
      mDone   = 1'b0;
      mProd   = '0;
    end else begin
      mDone = 1'b0;
      if (mRemain > 0) begin
        mRemain = mRemain - 1;
        if (mRemain == 0) begin
          mProd = mPending;
          mDone = 1'b1;
        end
      end else if (start) begin
        mPending = refMul(multiplicand, multiplier);
        mRemain  = 16;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, (mRemain > 0)});
      checkOutput("done", {31'b0, done}, {31'b0, mDone});
      checkOutput("product", product, mProd);
    end
  end

  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic waitDone(input string name, input logic [31:0] lit, input int offset, output int busyCnt);
    int cyc;
    bit seen;
    cyc     = offset;
    seen    = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busyCnt++;
    end
    checkOutput({name, " done seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      checkOutput({name, " latency"}, cyc, 32'd17);
      checkOutput({name, " value"}, product, lit);
    end
  endtask

  initial begin
    int bc;
    int doneCnt;
    logic [15:0] m;
    logic [15:0] q;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkEn = 1'b1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset product", product, 32'd0);
    @(negedge clk);

    applyStimulus(16'd3, 16'd5);
    waitDone("3x5", 32'h0000000F, 0, bc);
    checkOutput("3x5 busy cycles", bc, 32'd16);
    @(negedge clk);

    applyStimulus(16'hFFFF, 16'hFFFF);
    waitDone("-1x-1", 32'h00000001, 0, bc);
    @(negedge clk);
    applyStimulus(16'hFFF9, 16'd9);
    waitDone("-7x9", 32'hFFFFFFC1, 0, bc);
    @(negedge clk);

    applyStimulus(16'h8000, 16'h8000);
    waitDone("-32768x-32768", 32'h40000000, 0, bc);
    @(negedge clk);

    applyStimulus(16'h7FFF, 16'h8000);
    waitDone("32767x-32768", 32'hC0008000, 0, bc);
    repeat (2) @(negedge clk);
    applyStimulus(16'h0000, 16'h1234);
    repeat (8) @(negedge clk);
    checkOutput("hold mid-run", product, 32'hC0008000);
    waitDone("0x1234", 32'h00000000, 8, bc);
    @(negedge clk);

    // A start pulse at step 5 must be ignored; then a start in the DONE cycle chains the next op.
    applyStimulus(16'd100, 16'hFFFD);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    multiplicand = 16'd7;
    multiplier = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignored start", 32'hFFFFFED4, 5, bc);
    applyStimulus(16'h0123, 16'hFF00);
    waitDone("back-to-back", 32'hFFFEDD00, 0, bc);
    @(negedge clk);

    applyStimulus(16'h1234, 16'h0101);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {31'b0, busy}, 32'd0);
    checkOutput("async reset done", {31'b0, done}, 32'd0);
    checkOutput("async reset product", product, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("no done after reset", doneCnt, 32'd0);
    applyStimulus(16'hFED4, 16'h0011);
    waitDone("after reset", 32'hFFFFEC14, 0, bc);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: m = 16'h8000;
        1: m = 16'h7FFF;
        2: m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: q = 16'h8000;
        1: q = 16'h0000;
        2: q = 16'h7FFF;
        default: q = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(m, q);
      waitDone("random", refMul(m, q), 0, bc);
    end

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
